rotary_value_controller: RTL



---
 rtl/rotary_value_controller_pkg.sv | 20 ++
 rtl/rotary_value_controller_if.sv | 25 ++
 rtl/rotary_accel_tracker.sv | 83 ++++++++
 rtl/rotary_value_controller.sv | 121 ++++++++++++
 4 files changed

// File: rtl/rotary_value_controller_pkg.sv
// Shared definitions for the rotary value controller.
//   rot_state_t : acceleration FSM states
//   rot_step_t  : decoded step direction for one cycle
package rotary_value_controller_pkg;

    typedef enum logic [2:0] {
        ROT_IDLE      = 3'd0,
        ROT_TRACK_CW  = 3'd1,
        ROT_TRACK_CCW = 3'd2,
        ROT_FAST_CW   = 3'd3,
        ROT_FAST_CCW  = 3'd4
    } rot_state_t;

    typedef enum logic [1:0] {
        ROT_STEP_NONE = 2'd0,
        ROT_STEP_CW   = 2'd1,
        ROT_STEP_CCW  = 2'd2
    } rot_step_t;

endpackage

// File: rtl/rotary_value_controller_if.sv
// Bundle of the encoder step inputs, load override and value handshake.
//   master : encoder/host side (drives steps, load, out_ready)
//   slave  : controller side (drives value, out_valid, accel_active)
interface rotary_value_controller_if #(
    parameter int WIDTH = 8
);
    logic             step_cw;
    logic             step_ccw;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic [WIDTH-1:0] value;
    logic             out_valid;
    logic             out_ready;
    logic             accel_active;

    modport master (
        output step_cw, step_ccw, load, load_value, out_ready,
        input  value, out_valid, accel_active
    );

    modport slave (
        input  step_cw, step_ccw, load, load_value, out_ready,
        output value, out_valid, accel_active
    );
endinterface

// File: rtl/rotary_accel_tracker.sv
// Acceleration tracker: watches processed steps and raises accel_active
// after ACCEL_COUNT same-direction steps each closer than ACCEL_WINDOW cycles.
//   clk, rst_n      : clock, asynchronous active-low reset
//   dir_cw, dir_ccw : one processed step this cycle (never both)
//   clear           : return to IDLE (load override)
//   accel_active    : registered accelerated-mode flag
module rotary_accel_tracker
    import rotary_value_controller_pkg::*;
#(
    parameter int ACCEL_WINDOW = 2000000,
    parameter int ACCEL_COUNT  = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic dir_cw,
    input  logic dir_ccw,
    input  logic clear,
    output logic accel_active
);
    localparam int TW = $clog2(ACCEL_WINDOW + 2);
    localparam int SW = $clog2(ACCEL_COUNT + 2);
    localparam logic [TW-1:0] WIN = TW'(ACCEL_WINDOW);
    localparam logic [SW-1:0] CNT = SW'(ACCEL_COUNT);
    localparam logic [SW-1:0] ONE = SW'(1);

    rot_state_t    state_reg;
    logic [TW-1:0] timer_reg;
    logic [SW-1:0] streak_reg;
    logic          accel_reg;

    logic          same_dir;
    logic          fast_gap;
    logic [SW-1:0] streak_inc;
    rot_state_t    track_state;
    rot_state_t    fast_state;

    always_comb begin
        same_dir    = (dir_cw  && (state_reg == ROT_TRACK_CW  || state_reg == ROT_FAST_CW)) ||
                      (dir_ccw && (state_reg == ROT_TRACK_CCW || state_reg == ROT_FAST_CCW));
        fast_gap    = timer_reg < WIN;
        // Streak saturates at the threshold so it cannot overflow in FAST.
        streak_inc  = (streak_reg >= CNT) ? CNT : streak_reg + ONE;
        track_state = dir_cw ? ROT_TRACK_CW : ROT_TRACK_CCW;
        fast_state  = dir_cw ? ROT_FAST_CW  : ROT_FAST_CCW;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ROT_IDLE;
            timer_reg  <= '0;
            streak_reg <= '0;
            accel_reg  <= 1'b0;
        end else if (clear) begin
            state_reg  <= ROT_IDLE;
            timer_reg  <= '0;
            streak_reg <= '0;
            accel_reg  <= 1'b0;
        end else if (dir_cw || dir_ccw) begin
            timer_reg <= '0;
            if (same_dir && fast_gap) begin
                streak_reg <= streak_inc;
                state_reg  <= (streak_inc >= CNT) ? fast_state : track_state;
                accel_reg  <= (streak_inc >= CNT);
            end else begin
                // First step, reversal, or a too-slow same-direction step
                // all start a fresh streak.
                streak_reg <= ONE;
                state_reg  <= (ONE >= CNT) ? fast_state : track_state;
                accel_reg  <= (ONE >= CNT);
            end
        end else begin
            if (timer_reg != WIN) begin
                timer_reg <= timer_reg + TW'(1);
            end else if (state_reg != ROT_IDLE) begin
                state_reg  <= ROT_IDLE;
                streak_reg <= '0;
                accel_reg  <= 1'b0;
            end
        end
    end

    assign accel_active = accel_reg;
endmodule

// File: rtl/rotary_value_controller.sv
// Rotary value controller: turns encoder step pulses into a bounded setting
// with saturate/wrap limits, load override, acceleration and a coalescing
// valid/ready change handshake.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : step_cw/step_ccw/load/load_value/out_ready in,
//                value/out_valid/accel_active out
module rotary_value_controller
    import rotary_value_controller_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int MIN_VALUE    = 0,
    parameter int MAX_VALUE    = 255,
    parameter int INIT_VALUE   = 0,
    parameter int WRAP         = 0,
    parameter int ACCEL_WINDOW = 2000000,
    parameter int ACCEL_COUNT  = 3,
    parameter int ACCEL_STEP   = 10
) (
    input logic clk,
    input logic rst_n,
    rotary_value_controller_if.slave bus
);
    // One extra bit so value+step never overflows before range checks.
    localparam int AW = WIDTH + 1;
    localparam logic [AW-1:0]    MIN_W    = AW'(MIN_VALUE);
    localparam logic [AW-1:0]    MAX_W    = AW'(MAX_VALUE);
    localparam logic [AW-1:0]    STEP_ACC = AW'(ACCEL_STEP);
    localparam logic [AW-1:0]    STEP_ONE = AW'(1);
    localparam logic [WIDTH-1:0] INIT_W   = WIDTH'(INIT_VALUE);

    logic [WIDTH-1:0] value_reg;
    logic [WIDTH-1:0] value_next;
    logic             valid_reg;
    logic             valid_next;
    logic             accel;

    rot_step_t        step_dir;
    logic [AW-1:0]    step_amt;
    logic [AW-1:0]    cur;
    logic [AW-1:0]    sum;
    logic [AW-1:0]    load_clamped;
    logic [AW-1:0]    result;
    logic             changed;

    always_comb begin
        step_dir = ROT_STEP_NONE;
        if (bus.step_cw && !bus.step_ccw) begin
            step_dir = ROT_STEP_CW;
        end else if (bus.step_ccw && !bus.step_cw) begin
            step_dir = ROT_STEP_CCW;
        end

        step_amt = accel ? STEP_ACC : STEP_ONE;
        cur      = {1'b0, value_reg};
        sum      = cur + step_amt;

        if ({1'b0, bus.load_value} < MIN_W) begin
            load_clamped = MIN_W;
        end else if ({1'b0, bus.load_value} > MAX_W) begin
            load_clamped = MAX_W;
        end else begin
            load_clamped = {1'b0, bus.load_value};
        end

        result = cur;
        if (bus.load) begin
            result = load_clamped;
        end else if (step_dir == ROT_STEP_CW) begin
            if (sum > MAX_W) begin
                result = (WRAP != 0) ? MIN_W + (sum - MAX_W - STEP_ONE) : MAX_W;
            end else begin
                result = sum;
            end
        end else if (step_dir == ROT_STEP_CCW) begin
            // cur < MIN+step is the unsigned form of cur-step < MIN.
            if (cur < MIN_W + step_amt) begin
                result = (WRAP != 0) ? MAX_W - (MIN_W + step_amt - cur - STEP_ONE) : MIN_W;
            end else begin
                result = cur - step_amt;
            end
        end

        value_next = WIDTH'(result);
        changed    = value_next != value_reg;

        // A change in the same cycle as an accept keeps valid asserted.
        if (changed) begin
            valid_next = 1'b1;
        end else if (valid_reg && bus.out_ready) begin
            valid_next = 1'b0;
        end else begin
            valid_next = valid_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_reg <= INIT_W;
            valid_reg <= 1'b0;
        end else begin
            value_reg <= value_next;
            valid_reg <= valid_next;
        end
    end

    rotary_accel_tracker #(
        .ACCEL_WINDOW (ACCEL_WINDOW),
        .ACCEL_COUNT  (ACCEL_COUNT)
    ) u_tracker (
        .clk          (clk),
        .rst_n        (rst_n),
        .dir_cw       (!bus.load && step_dir == ROT_STEP_CW),
        .dir_ccw      (!bus.load && step_dir == ROT_STEP_CCW),
        .clear        (bus.load),
        .accel_active (accel)
    );

    assign bus.value        = value_reg;
    assign bus.out_valid    = valid_reg;
    assign bus.accel_active = accel;
endmodule
